// File: rtl/mcash_assert_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mcash_assert_pkg
//  Description : Shared types and helper functions for the assert event
//                collector. Holds the error and scan FSM state encodings, a
//                width-parameterised saturating add, a popcount and a
//                lowest-set-bit finder. All helpers work on 64-bit operands so
//                they serve every legal NSRC/CW combination.
//  Revision    : 1.0 - initial release
// ============================================================================
package mcash_assert_pkg;

    localparam int unsigned c_FUNC_W = 64;

    // Error FSM: RUN -> ERROR -> FATAL. FATAL is sticky until CLR or RST.
    typedef enum logic [1:0] {
        E_RUN   = 2'd0,
        E_ERROR = 2'd1,
        E_FATAL = 2'd2
    } err_state_e;

    // Scan FSM: IDLE -> LOAD (first beat shown) -> BEAT (later beats) -> DONE.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_BEAT = 2'd2,
        S_DONE = 2'd3
    } scan_state_e;

    // value + inc, clamped to the largest value representable in 'width' bits.
    // The sum is formed one bit wider so a carry out of bit 63 is never lost.
    function automatic logic [c_FUNC_W-1:0] sat_inc(
        input logic [c_FUNC_W-1:0] value,
        input logic [c_FUNC_W-1:0] inc,
        input int unsigned         width
    );
        logic [c_FUNC_W:0]   sum;
        logic [c_FUNC_W-1:0] max;
        max = (width >= c_FUNC_W) ? '1 : ((64'd1 << width) - 64'd1);
        sum = {1'b0, value} + {1'b0, inc};
        if (sum > {1'b0, max}) begin
            return max;
        end
        return sum[c_FUNC_W-1:0];
    endfunction

    function automatic logic [6:0] popcount(input logic [c_FUNC_W-1:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < c_FUNC_W; i++) begin
            n = n + {6'd0, v[i]};
        end
        return n;
    endfunction

    // Scans from the top down so the last hit written is the lowest index.
    function automatic logic [5:0] lowest_set(input logic [c_FUNC_W-1:0] v);
        logic [5:0] idx;
        idx = '0;
        for (int i = c_FUNC_W - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 6'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/assert_sat_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : assert_sat_cnt
//  Description : Saturating up-counter with synchronous clear, enable and a
//                variable increment amount. Never wraps.
//  Ports       : CLK  - clock
//                RST  - asynchronous active-high reset
//                CLR  - synchronous clear (wins over EN)
//                EN   - add INC this cycle
//                INC  - increment amount
//                CNT  - current count
//  Revision    : 1.0 - initial release
// ============================================================================
module assert_sat_cnt
    import mcash_assert_pkg::*;
#(
    parameter int W  = 16,
    parameter int IW = 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          CLR,
    input  logic          EN,
    input  logic [IW-1:0] INC,
    output logic [W-1:0]  CNT
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (CLR) begin
            r_cnt <= '0;
        end else if (EN) begin
            r_cnt <= W'(sat_inc(64'(r_cnt), 64'(INC), W));
        end
    end

    assign CNT = r_cnt;

endmodule
`default_nettype wire

// File: rtl/assert_event_collector.sv
`default_nettype none
// ============================================================================
//  Module      : assert_event_collector
//  Description : Collects per-checker fail pulses from the X-checkers. Keeps
//                saturating per-source and total error counts, captures the
//                first failing source and its timestamp, raises a sticky
//                FATAL at a threshold and offers a valid/ready scan port that
//                reads every per-source counter out in index order.
//  Ports       : CLK, RST              - clock, async active-high reset
//                EN                    - count enable (timestamp always runs)
//                ERR[NSRC]             - per-source fail pulses
//                CLR                   - synchronous clear (not timestamp)
//                ANY_ERR, FATAL        - sticky status
//                FIRST_SRC, FIRST_TIME - first error capture
//                TOTAL_CNT             - saturating total
//                SCAN_START            - begin readout (ignored unless idle)
//                RD_VLD/RD_RDY         - readout handshake
//                RD_IDX, RD_CNT        - readout beat payload
//                SCAN_DONE             - pulse after last beat accepted
//  Revision    : 1.0 - initial release
// ============================================================================
module assert_event_collector
    import mcash_assert_pkg::*;
#(
    parameter int NSRC         = 8,
    parameter int CW           = 16,
    parameter int TW           = 32,
    parameter int FATAL_THRESH = 1,
    localparam int c_IW        = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            EN,
    input  logic [NSRC-1:0] ERR,
    input  logic            CLR,
    output logic            ANY_ERR,
    output logic            FATAL,
    output logic [c_IW-1:0] FIRST_SRC,
    output logic [TW-1:0]   FIRST_TIME,
    output logic [CW-1:0]   TOTAL_CNT,
    input  logic            SCAN_START,
    output logic            RD_VLD,
    input  logic            RD_RDY,
    output logic [c_IW-1:0] RD_IDX,
    output logic [CW-1:0]   RD_CNT,
    output logic            SCAN_DONE
);

    localparam int              c_PW       = $clog2(NSRC + 1);
    localparam logic [c_IW-1:0] c_LAST_IDX = c_IW'(NSRC - 1);
    localparam logic [CW-1:0]   c_THRESH   = CW'(FATAL_THRESH);

    logic [NSRC-1:0] w_err;
    logic            w_any;
    logic            w_cnt_en;
    logic [c_PW-1:0] w_pop;
    logic [CW-1:0]   w_total;
    logic [CW-1:0]   w_total_nxt;
    logic [CW-1:0]   w_cnt [NSRC];
    logic [c_IW-1:0] w_nxt_idx;

    logic [TW-1:0]   r_ts;
    err_state_e      r_err_state;
    logic            r_any_err;
    logic            r_fatal;
    logic [c_IW-1:0] r_first_src;
    logic [TW-1:0]   r_first_time;

    scan_state_e     r_scan_state;
    logic            r_rd_vld;
    logic [c_IW-1:0] r_rd_idx;
    logic [CW-1:0]   r_rd_cnt;
    logic            r_scan_done;

    // An unknown fail bit is treated as a failure rather than silently dropped.
    always_comb begin
        w_err = '0;
        for (int i = 0; i < NSRC; i++) begin
            w_err[i] = (ERR[i] !== 1'b0);
        end
    end

    assign w_any       = |w_err;
    assign w_cnt_en    = EN && !CLR;
    assign w_pop       = c_PW'(popcount(64'(w_err)));
    // Same value the total counter will hold after this edge; FATAL keys off it
    // so the threshold can trip in the very cycle the errors arrive.
    assign w_total_nxt = CW'(sat_inc(64'(w_total), 64'(w_pop), CW));
    assign w_nxt_idx   = r_rd_idx + c_IW'(1);

    generate
        for (genvar g = 0; g < NSRC; g++) begin : g_src_cnt
            assert_sat_cnt #(
                .W  (CW),
                .IW (1)
            ) u_cnt (
                .CLK (CLK),
                .RST (RST),
                .CLR (CLR),
                .EN  (w_cnt_en & w_err[g]),
                .INC (1'b1),
                .CNT (w_cnt[g])
            );
        end
    endgenerate

    assert_sat_cnt #(
        .W  (CW),
        .IW (c_PW)
    ) u_total (
        .CLK (CLK),
        .RST (RST),
        .CLR (CLR),
        .EN  (w_cnt_en),
        .INC (w_pop),
        .CNT (w_total)
    );

    // Free-running timestamp; deliberately untouched by CLR.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_err_state  <= E_RUN;
            r_any_err    <= 1'b0;
            r_fatal      <= 1'b0;
            r_first_src  <= '0;
            r_first_time <= '0;
        end else if (CLR) begin
            r_err_state  <= E_RUN;
            r_any_err    <= 1'b0;
            r_fatal      <= 1'b0;
            r_first_src  <= '0;
            r_first_time <= '0;
        end else if (w_cnt_en && w_any) begin
            if (!r_any_err) begin
                r_any_err    <= 1'b1;
                r_first_src  <= c_IW'(lowest_set(64'(w_err)));
                r_first_time <= r_ts;
            end
            if (w_total_nxt >= c_THRESH) begin
                r_err_state <= E_FATAL;
                r_fatal     <= 1'b1;
            end else if (r_err_state == E_RUN) begin
                r_err_state <= E_ERROR;
            end
        end
    end

    // Each beat is a snapshot taken when it is loaded; RD_IDX/RD_CNT only
    // change on an accepted beat, which gives stall stability for free.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_scan_state <= S_IDLE;
            r_rd_vld     <= 1'b0;
            r_rd_idx     <= '0;
            r_rd_cnt     <= '0;
            r_scan_done  <= 1'b0;
        end else if (CLR) begin
            r_scan_state <= S_IDLE;
            r_rd_vld     <= 1'b0;
            r_rd_idx     <= '0;
            r_rd_cnt     <= '0;
            r_scan_done  <= 1'b0;
        end else begin
            r_scan_done <= 1'b0;
            case (r_scan_state)
                S_IDLE: begin
                    if (SCAN_START) begin
                        r_rd_idx     <= '0;
                        r_rd_cnt     <= w_cnt[0];
                        r_rd_vld     <= 1'b1;
                        r_scan_state <= S_LOAD;
                    end
                end
                S_LOAD, S_BEAT: begin
                    if (RD_RDY) begin
                        if (r_rd_idx == c_LAST_IDX) begin
                            r_rd_vld     <= 1'b0;
                            r_scan_done  <= 1'b1;
                            r_scan_state <= S_DONE;
                        end else begin
                            r_rd_idx     <= w_nxt_idx;
                            r_rd_cnt     <= w_cnt[w_nxt_idx];
                            r_scan_state <= S_BEAT;
                        end
                    end
                end
                S_DONE: begin
                    r_scan_state <= S_IDLE;
                end
                default: begin
                    r_scan_state <= S_IDLE;
                end
            endcase
        end
    end

    generate
        if (NSRC == 1) begin : g_idx_tie
            assign FIRST_SRC = '0;
            assign RD_IDX    = '0;
        end else begin : g_idx_reg
            assign FIRST_SRC = r_first_src;
            assign RD_IDX    = r_rd_idx;
        end
    endgenerate

    assign ANY_ERR    = r_any_err;
    assign FATAL      = r_fatal;
    assign FIRST_TIME = r_first_time;
    assign TOTAL_CNT  = w_total;
    assign RD_VLD     = r_rd_vld;
    assign RD_CNT     = r_rd_cnt;
    assign SCAN_DONE  = r_scan_done;

endmodule
`default_nettype wire

// File: doc/assert_event_collector.md
Name: assert_event_collector

Overview:
- Sits directly downstream of the per-register X-checkers in the simulation assert layer.
- Consumes one fail pulse per checker per cycle and keeps saturating per-source and total error counts.
- Captures the first failing source and its cycle timestamp, and raises a sticky FATAL once a threshold is reached.
- Provides a handshaked scan port so the testbench or a debug block can read out all counters.

Parameters:
- NSRC, 8: number of checker sources (1..64).
- CW, 16: width of per-source and total counters.
- TW, 32: width of the free-running cycle timestamp.
- FATAL_THRESH, 1: total error count at which FATAL asserts (1..2^CW-1).

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  asynchronous active-high reset.
- EN  in  1  count enable; when 0, ERR is ignored (timestamp still runs).
- ERR  in  NSRC  per-source fail pulse; bit i high = checker i failed this cycle.
- CLR  in  1  synchronous clear of counters, first-error capture, FATAL, scan.
- ANY_ERR  out  1  sticky; at least one error counted since RST/CLR.
- FATAL  out  1  sticky; total count >= FATAL_THRESH.
- FIRST_SRC  out  $clog2(NSRC) (min 1)  index of first failing source.
- FIRST_TIME  out  TW  timestamp of first failure.
- TOTAL_CNT  out  CW  saturating total error count.
- SCAN_START  in  1  pulse; begin counter readout.
- RD_VLD  out  1  readout beat valid.
- RD_RDY  in  1  consumer accepts beat.
- RD_IDX  out  $clog2(NSRC) (min 1)  source index of beat.
- RD_CNT  out  CW  counter value of beat.
- SCAN_DONE  out  1  one-cycle pulse after last beat accepted.

Behaviour:
- Reset (async, RST=1): every output is 0, every counter is 0, timestamp is 0, FSM is RUN/IDLE.
- Timestamp:
  - Increments every cycle RST=0, wraps modulo 2^TW.
  - Not affected by CLR.
- Counting (EN=1, CLR=0):
  - For each bit with ERR[i]==1, cnt[i] increments and saturates at 2^CW-1.
  - TOTAL_CNT += popcount(ERR), saturating (never wraps).
  - Results are visible the cycle after the ERR sample.
- X/Z handling: in simulation an ERR bit that is X/Z (i.e. !== 0) counts as an error.
- First-error capture: on the first counting cycle after RST/CLR with any error, FIRST_SRC is the lowest set index and FIRST_TIME is the timestamp of that cycle. Both are frozen afterward. ANY_ERR sets in the same update.
- Error FSM states RUN → ERROR → FATAL:
  - RUN → ERROR on the first counted error.
  - ERROR (or RUN) → FATAL when the updated total >= FATAL_THRESH. This may happen in the same cycle as the first error if the threshold is met.
  - FATAL is sticky; counting continues while in FATAL.
  - Only CLR or RST returns the FSM to RUN.
- Scan FSM states IDLE → LOAD → BEAT → DONE:
  - SCAN_START in IDLE → LOAD: snapshot cnt[0] into RD_CNT, RD_IDX=0, RD_VLD=1 next cycle.
  - RD_VLD && RD_RDY with idx < NSRC-1: load the next index the next cycle, giving back-to-back beats with no bubble.
  - RD_VLD && RD_RDY at idx == NSRC-1: RD_VLD=0 and SCAN_DONE=1 for one cycle, then IDLE.
  - RD_IDX and RD_CNT hold stable while RD_VLD && !RD_RDY. The snapshot is taken at load and does not reflect later increments.
  - SCAN_START while not IDLE is ignored.
- CLR priority:
  - Counters, TOTAL_CNT, ANY_ERR, FATAL, FIRST_* are zeroed the next cycle.
  - ERR in the same cycle as CLR is discarded.
  - CLR during a scan aborts it: RD_VLD=0 next cycle, no SCAN_DONE pulse.
  - CLR together with SCAN_START: clear wins, scan does not start.
- NSRC=1: index outputs are 1 bit wide and tied to 0.

Decomposition:
- mcash_assert_pkg holds:
  - err_state_e (RUN, ERROR, FATAL) and scan_state_e (IDLE, LOAD, BEAT, DONE);
  - a sat_inc function (value, increment, width);
  - a popcount function;
  - a lowest-set-index function.
- One sub-module: assert_sat_cnt, a parameterised saturating counter with clear, enable and increment amount. It is instantiated NSRC times plus once for the total.

Test Plan:
- Reset then idle 10 cycles, EN=1, ERR=0 → all outputs 0; timestamp is 10 after 10 cycles.
- FATAL_THRESH=3, ERR=8'b0000_0101 at t=5, ERR=8'b0001_0000 at t=9 → FIRST_SRC=0, FIRST_TIME=5, TOTAL_CNT=3, FATAL rises the cycle after t=9, ANY_ERR=1.
- CW=4, ERR[2] held high 20 cycles → cnt[2] and TOTAL_CNT stick at 15 with no wrap.
- Scan with NSRC=8, RD_RDY low on beat 3 for 4 cycles → 8 beats in index order; beat 3 is stable across the stall; RD_CNT values match snapshots; SCAN_DONE pulses once.
- CLR asserted at beat 5 together with ERR=8'hFF → RD_VLD drops, no SCAN_DONE, all counters 0, FATAL=0, ANY_ERR=0.
- RST pulsed asynchronously mid-cycle during FATAL with a scan active → outputs go to 0 immediately; after release, the timestamp restarts from 0.
